// File: rtl/hilo_fwd_file.sv
// rtl/hilo_fwd_file.sv - HI/LO register file with read forwarding and MDU scoreboard; optional stall counter under HILO_STALL_CNT_EN
module hilo_fwd_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_FWD  = 2,
    parameter int MAX_PEND = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wb_hi_we,
    input  logic                        wb_lo_we,
    input  logic [DATA_W-1:0]           wb_hi,
    input  logic [DATA_W-1:0]           wb_lo,
    input  logic [NUM_FWD-1:0]          fwd_hi_we,
    input  logic [NUM_FWD-1:0]          fwd_lo_we,
    input  logic [NUM_FWD*DATA_W-1:0]   fwd_hi,
    input  logic [NUM_FWD*DATA_W-1:0]   fwd_lo,
    input  logic                        mdu_issue,
    input  logic                        mdu_done,
    input  logic                        mdu_cancel,
    input  logic                        rd_req,
    output logic [DATA_W-1:0]           hi_o,
    output logic [DATA_W-1:0]           lo_o,
    output logic                        stall_o,
    output logic [$clog2(MAX_PEND+1)-1:0] pend_o,
    output logic                        err_o,
    output logic [31:0]                 stall_cnt_o
);

    localparam int PEND_W = $clog2(MAX_PEND+1);

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [PEND_W-1:0] r_pend;
    logic              r_err;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_lo;
    logic              w_stall;

    // Architectural HI/LO storage; the two halves are written independently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (wb_hi_we) r_hi <= wb_hi;
            if (wb_lo_we) r_lo <= wb_lo;
        end
    end

    // Per-half read mux: youngest valid forward stage, then writeback write-through, then storage.
    // Walking from the oldest stage down lets the lowest index overwrite and win.
    always_comb begin
        w_hi = wb_hi_we ? wb_hi : r_hi;
        w_lo = wb_lo_we ? wb_lo : r_lo;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_hi_we[i]) w_hi = fwd_hi[i*DATA_W +: DATA_W];
            if (fwd_lo_we[i]) w_lo = fwd_lo[i*DATA_W +: DATA_W];
        end
    end

    // Outstanding MDU op count; flush wins, over/underflow saturate and latch the sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_err  <= 1'b0;
        end else if (mdu_cancel) begin
            r_pend <= '0;
        end else if (mdu_issue && !mdu_done) begin
            if (r_pend == PEND_W'(MAX_PEND)) r_err  <= 1'b1;
            else                             r_pend <= r_pend + PEND_W'(1);
        end else if (mdu_done && !mdu_issue) begin
            if (r_pend == '0) r_err  <= 1'b1;
            else              r_pend <= r_pend - PEND_W'(1);
        end
    end

    // The retiring op's result reaches the reader through writeback forwarding, so only
    // the registered count gates the stall
    assign w_stall = rd_req && (r_pend != '0);

    assign hi_o    = w_hi;
    assign lo_o    = w_lo;
    assign stall_o = w_stall;
    assign pend_o  = r_pend;
    assign err_o   = r_err;

`ifdef HILO_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Free-running count of stalled cycles; wraps naturally and ignores pipeline flushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_stall_cnt <= '0;
        else if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hilo_fwd_file.sv
// tb/tb_hilo_fwd_file.sv - directed self-checking bench for hilo_fwd_file
module tb_hilo_fwd_file;

    logic        clk;
    logic        rst_n;
    logic        wb_hi_we, wb_lo_we;
    logic [31:0] wb_hi, wb_lo;
    logic [1:0]  fwd_hi_we, fwd_lo_we;
    logic [63:0] fwd_hi, fwd_lo;
    logic        mdu_issue, mdu_done, mdu_cancel, rd_req;
    logic [31:0] hi_o, lo_o;
    logic        stall_o;
    logic [1:0]  pend_o;
    logic        err_o;
    logic [31:0] stall_cnt_o;

    int n_total = 0;
    int n_pass  = 0;

`ifdef HILO_STALL_CNT_EN
    localparam logic [31:0] EXP_CNT5 = 32'd5;
`else
    localparam logic [31:0] EXP_CNT5 = 32'd0;
`endif

    hilo_fwd_file dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_hi_we    (wb_hi_we),
        .wb_lo_we    (wb_lo_we),
        .wb_hi       (wb_hi),
        .wb_lo       (wb_lo),
        .fwd_hi_we   (fwd_hi_we),
        .fwd_lo_we   (fwd_lo_we),
        .fwd_hi      (fwd_hi),
        .fwd_lo      (fwd_lo),
        .mdu_issue   (mdu_issue),
        .mdu_done    (mdu_done),
        .mdu_cancel  (mdu_cancel),
        .rd_req      (rd_req),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .stall_o     (stall_o),
        .pend_o      (pend_o),
        .err_o       (err_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        wb_hi_we = 0; wb_lo_we = 0; wb_hi = 0; wb_lo = 0;
        fwd_hi_we = 0; fwd_lo_we = 0; fwd_hi = 0; fwd_lo = 0;
        mdu_issue = 0; mdu_done = 0; mdu_cancel = 0; rd_req = 0;
        #2;
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        chk("rst_pend", pend_o, 32'h0);
        chk("rst_err", err_o, 32'h0);
        chk("rst_stall", stall_o, 32'h0);
        chk("rst_cnt", stall_cnt_o, 32'h0);
        #10 rst_n = 1'b1;
        tick();

        // 1: write-through then storage
        wb_hi_we = 1; wb_hi = 32'h1234; wb_lo_we = 1; wb_lo = 32'hABCD;
        #1;
        chk("t1_hi_wt", hi_o, 32'h1234);
        chk("t1_lo_wt", lo_o, 32'hABCD);
        tick();
        wb_hi_we = 0; wb_lo_we = 0; wb_hi = 0; wb_lo = 0;
        #1;
        chk("t1_hi_q", hi_o, 32'h1234);
        chk("t1_lo_q", lo_o, 32'hABCD);

        // 2: forwarding priority
        tick();
        wb_hi_we = 1; wb_hi = 32'h11;
        tick();
        wb_hi_we = 1; wb_hi = 32'hCC;
        fwd_hi_we = 2'b11; fwd_hi = {32'hBB, 32'hAA};
        fwd_lo_we = 2'b00; fwd_lo = {32'hDD, 32'h77};
        #1;
        chk("t2_hi_fwd0", hi_o, 32'hAA);
        chk("t2_lo_q", lo_o, 32'hABCD);
        fwd_hi_we = 2'b10;
        #1;
        chk("t2_hi_fwd1", hi_o, 32'hBB);
        fwd_lo_we = 2'b01;
        #1;
        chk("t2_lo_fwd0", lo_o, 32'h77);
        chk("t2_hi_noshadow", hi_o, 32'hBB);
        fwd_hi_we = 2'b00;
        #1;
        chk("t2_hi_wb", hi_o, 32'hCC);
        wb_hi_we = 0; fwd_lo_we = 0; fwd_hi = 0; fwd_lo = 0;
        #1;
        chk("t2_hi_q", hi_o, 32'h11);

        // 3: single MDU op stalls reader until done
        tick();
        rd_req = 1; mdu_issue = 1;
        #1;
        chk("t3_nostall_pre", stall_o, 32'h0);
        tick();
        mdu_issue = 0;
        #1;
        chk("t3_stall", stall_o, 32'h1);
        chk("t3_pend1", pend_o, 32'h1);
        mdu_done = 1; wb_hi_we = 1; wb_hi = 32'h55;
        #1;
        chk("t3_hi_done", hi_o, 32'h55);
        tick();
        mdu_done = 0; wb_hi_we = 0; wb_hi = 0;
        #1;
        chk("t3_stall_off", stall_o, 32'h0);
        chk("t3_pend0", pend_o, 32'h0);
        chk("t3_hi_q", hi_o, 32'h55);
        rd_req = 0;

        // 4: saturation at MAX_PEND and flush
        mdu_issue = 1;
        tick(); tick(); tick();
        chk("t4_pend3", pend_o, 32'h3);
        chk("t4_err0", err_o, 32'h0);
        tick();
        chk("t4_pend_sat", pend_o, 32'h3);
        chk("t4_err_ovf", err_o, 32'h1);
        mdu_done = 1;
        tick();
        chk("t4_pend_both", pend_o, 32'h3);
        mdu_cancel = 1;
        tick();
        mdu_cancel = 0; mdu_issue = 0; mdu_done = 0;
        #1;
        chk("t4_pend_cancel", pend_o, 32'h0);
        chk("t4_err_sticky", err_o, 32'h1);

        // 5: underflow, then async reset mid-operation
        rst_n = 0;
        #1;
        rst_n = 1;
        chk("t5_err_clr", err_o, 32'h0);
        chk("t5_hi_clr", hi_o, 32'h0);
        tick();
        mdu_done = 1;
        tick();
        mdu_done = 0;
        #1;
        chk("t5_err_unf", err_o, 32'h1);
        chk("t5_pend_unf", pend_o, 32'h0);
        mdu_issue = 1;
        tick(); tick();
        mdu_issue = 0; rd_req = 1;
        #1;
        chk("t5_pend2", pend_o, 32'h2);
        chk("t5_stall2", stall_o, 32'h1);
        rst_n = 0;
        #1;
        chk("t5_arst_pend", pend_o, 32'h0);
        chk("t5_arst_stall", stall_o, 32'h0);
        chk("t5_arst_err", err_o, 32'h0);
        chk("t5_arst_cnt", stall_cnt_o, 32'h0);
        rst_n = 1;

        // 6: stall-cycle counter
        tick();
        mdu_issue = 1;
        tick();
        mdu_issue = 0;
        #1;
        chk("t6_cnt0", stall_cnt_o, 32'h0);
        tick(); tick(); tick(); tick(); tick();
        chk("t6_cnt5", stall_cnt_o, EXP_CNT5);
`ifdef HILO_STALL_CNT_EN
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        tick();
        chk("t6_cnt_wrap", stall_cnt_o, 32'h0);
`else
        tick();
        chk("t6_cnt_tied", stall_cnt_o, 32'h0);
`endif
        mdu_cancel = 1;
        tick();
        mdu_cancel = 0; rd_req = 0;
        #1;
        chk("t6_stall_cancel", stall_o, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
